// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline: ALU operation codes, operand
// select encodings and the EX-stage control bundle with its bubble value.
package rv_pipe_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_BEQ  = 5'b01000;
  localparam logic [4:0] ALU_BNE  = 5'b01001;
  localparam logic [4:0] ALU_BLT  = 5'b01100;
  localparam logic [4:0] ALU_SUB  = 5'b10000;
  localparam logic [4:0] ALU_MUL  = 5'b11000;
  localparam logic [4:0] ALU_DIV  = 5'b11100;
  localparam logic [4:0] ALU_REM  = 5'b11101;

  localparam logic OP1_SEL_RS1 = 1'b0;
  localparam logic OP1_SEL_PC  = 1'b1;
  localparam logic OP2_SEL_RS2 = 1'b0;
  localparam logic OP2_SEL_IMM = 1'b1;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic op1_sel;
    logic op2_sel;
  } ex_ctrl_t;

  // A bubble is an invalid instruction with every side effect disabled.
  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass for one source register: EX/MEM has priority over MEM/WB,
// and x0 always reads the register file value.
module forward_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    if (rs_addr != '0) begin
      if (exmem_reg_write && (exmem_rd_addr == rs_addr)) begin
        fwd_data = exmem_result;
      end else if (memwb_reg_write && (memwb_rd_addr == rs_addr)) begin
        fwd_data = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection, forwarding, load-use stall,
// flush and hold. Define ID_EX_PERF_CNT_EN to add stall/flush counters.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [XLEN-1:0]       ID_PC,
  input  logic [XLEN-1:0]       ID_RS1_DATA,
  input  logic [XLEN-1:0]       ID_RS2_DATA,
  input  logic [XLEN-1:0]       ID_IMM,
  input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RD_ADDR,
  input  logic [ALUOP_W-1:0]    ID_ALUOP,
  input  logic                  ID_OP1_SEL,
  input  logic                  ID_OP2_SEL,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  ID_MEM_WRITE,
  input  logic [REG_ADDR_W-1:0] EXMEM_RD_ADDR,
  input  logic                  EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]       EXMEM_RESULT,
  input  logic [REG_ADDR_W-1:0] MEMWB_RD_ADDR,
  input  logic                  MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]       MEMWB_RESULT,
  input  logic                  FLUSH,
  input  logic                  HOLD,
  output logic [XLEN-1:0]       DATA1,
  output logic [XLEN-1:0]       DATA2,
  output logic [ALUOP_W-1:0]    SELECT,
  output logic                  EX_VALID,
  output logic [XLEN-1:0]       EX_PC,
  output logic [REG_ADDR_W-1:0] EX_RD_ADDR,
  output logic                  EX_REG_WRITE,
  output logic                  EX_MEM_READ,
  output logic                  EX_MEM_WRITE,
  output logic [XLEN-1:0]       EX_STORE_DATA,
  output logic                  STALL_ID
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           PERF_STALL_CNT,
  output logic [31:0]           PERF_FLUSH_CNT
`endif
);

  ex_ctrl_t              ctrl_reg,     ctrl_next;
  logic [XLEN-1:0]       pc_reg,       pc_next;
  logic [XLEN-1:0]       rs1_data_reg, rs1_data_next;
  logic [XLEN-1:0]       rs2_data_reg, rs2_data_next;
  logic [XLEN-1:0]       imm_reg,      imm_next;
  logic [REG_ADDR_W-1:0] rs1_addr_reg, rs1_addr_next;
  logic [REG_ADDR_W-1:0] rs2_addr_reg, rs2_addr_next;
  logic [REG_ADDR_W-1:0] rd_reg,       rd_next;
  logic [ALUOP_W-1:0]    aluop_reg,    aluop_next;

  logic load_use;
  logic kill;

  // The load in EX cannot supply its data before the consumer needs it.
  assign load_use = ctrl_reg.valid && ctrl_reg.mem_read && ID_VALID && (rd_reg != '0) &&
                    ((rd_reg == ID_RS1_ADDR) || (rd_reg == ID_RS2_ADDR));
  assign kill     = FLUSH || load_use || !ID_VALID;

  // A flushed ID instruction is dead, so it need not be held behind a load.
  assign STALL_ID = HOLD || (load_use && !FLUSH);

  always_comb begin
    ctrl_next     = ctrl_reg;
    pc_next       = pc_reg;
    rs1_data_next = rs1_data_reg;
    rs2_data_next = rs2_data_reg;
    imm_next      = imm_reg;
    rs1_addr_next = rs1_addr_reg;
    rs2_addr_next = rs2_addr_reg;
    rd_next       = rd_reg;
    aluop_next    = aluop_reg;
    if (!HOLD) begin
      if (kill) begin
        ctrl_next     = CTRL_BUBBLE;
        pc_next       = '0;
        rs1_data_next = '0;
        rs2_data_next = '0;
        imm_next      = '0;
        rs1_addr_next = '0;
        rs2_addr_next = '0;
        rd_next       = '0;
        aluop_next    = '0;
      end else begin
        ctrl_next.valid     = 1'b1;
        ctrl_next.reg_write = ID_REG_WRITE;
        ctrl_next.mem_read  = ID_MEM_READ;
        ctrl_next.mem_write = ID_MEM_WRITE;
        ctrl_next.op1_sel   = ID_OP1_SEL;
        ctrl_next.op2_sel   = ID_OP2_SEL;
        pc_next       = ID_PC;
        rs1_data_next = ID_RS1_DATA;
        rs2_data_next = ID_RS2_DATA;
        imm_next      = ID_IMM;
        rs1_addr_next = ID_RS1_ADDR;
        rs2_addr_next = ID_RS2_ADDR;
        rd_next       = ID_RD_ADDR;
        aluop_next    = ID_ALUOP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_reg     <= CTRL_BUBBLE;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_addr_reg <= '0;
      rs2_addr_reg <= '0;
      rd_reg       <= '0;
      aluop_reg    <= '0;
    end else begin
      ctrl_reg     <= ctrl_next;
      pc_reg       <= pc_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      imm_reg      <= imm_next;
      rs1_addr_reg <= rs1_addr_next;
      rs2_addr_reg <= rs2_addr_next;
      rd_reg       <= rd_next;
      aluop_reg    <= aluop_next;
    end
  end

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [XLEN-1:0]       src_data [2];
  logic [XLEN-1:0]       fwd_data [2];

  assign src_addr[0] = rs1_addr_reg;
  assign src_addr[1] = rs2_addr_reg;
  assign src_data[0] = rs1_data_reg;
  assign src_data[1] = rs2_data_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_forward_unit (
      .rs_addr         (src_addr[gi]),
      .rf_data         (src_data[gi]),
      .exmem_rd_addr   (EXMEM_RD_ADDR),
      .exmem_reg_write (EXMEM_REG_WRITE),
      .exmem_result    (EXMEM_RESULT),
      .memwb_rd_addr   (MEMWB_RD_ADDR),
      .memwb_reg_write (MEMWB_REG_WRITE),
      .memwb_result    (MEMWB_RESULT),
      .fwd_data        (fwd_data[gi])
    );
  end

  assign DATA1         = (ctrl_reg.op1_sel == OP1_SEL_PC)  ? pc_reg  : fwd_data[0];
  assign DATA2         = (ctrl_reg.op2_sel == OP2_SEL_IMM) ? imm_reg : fwd_data[1];
  assign EX_STORE_DATA = fwd_data[1];
  assign SELECT        = aluop_reg;
  assign EX_VALID      = ctrl_reg.valid;
  assign EX_PC         = pc_reg;
  assign EX_RD_ADDR    = rd_reg;
  assign EX_REG_WRITE  = ctrl_reg.reg_write;
  assign EX_MEM_READ   = ctrl_reg.mem_read;
  assign EX_MEM_WRITE  = ctrl_reg.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_reg;
  logic [31:0] perf_flush_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_stall_cnt_reg <= '0;
      perf_flush_cnt_reg <= '0;
    end else if (!HOLD) begin
      if (load_use) perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
      if (FLUSH)    perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
    end
  end

  assign PERF_STALL_CNT = perf_stall_cnt_reg;
  assign PERF_FLUSH_CNT = perf_flush_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// stall/flush/hold sequences, and randomized traffic against a reference model.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALUOP;
  logic        ID_OP1_SEL, ID_OP2_SEL, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic [4:0]  EXMEM_RD_ADDR, MEMWB_RD_ADDR;
  logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
  logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
  logic        FLUSH, HOLD;
  logic [31:0] DATA1, DATA2, EX_PC, EX_STORE_DATA;
  logic [4:0]  SELECT, EX_RD_ADDR;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, STALL_ID;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] PERF_STALL_CNT, PERF_FLUSH_CNT;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  id_ex_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_ALUOP(ID_ALUOP), .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RESULT(MEMWB_RESULT),
    .FLUSH(FLUSH), .HOLD(HOLD), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR),
    .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
    .EX_STORE_DATA(EX_STORE_DATA), .STALL_ID(STALL_ID)
`ifdef ID_EX_PERF_CNT_EN
    , .PERF_STALL_CNT(PERF_STALL_CNT), .PERF_FLUSH_CNT(PERF_FLUSH_CNT)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ID_VALID = 0; ID_PC = 0; ID_RS1_DATA = 0; ID_RS2_DATA = 0; ID_IMM = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_RD_ADDR = 0; ID_ALUOP = 0;
    ID_OP1_SEL = 0; ID_OP2_SEL = 0; ID_REG_WRITE = 0; ID_MEM_READ = 0; ID_MEM_WRITE = 0;
    EXMEM_RD_ADDR = 0; EXMEM_REG_WRITE = 0; EXMEM_RESULT = 0;
    MEMWB_RD_ADDR = 0; MEMWB_REG_WRITE = 0; MEMWB_RESULT = 0;
    FLUSH = 0; HOLD = 0;
  endtask

  // ---------------- reference model: the instruction sitting in EX ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, aluop;
    logic        op1, op2, rw, mr, mw;
  } instr_t;

  instr_t ex_m;
  int     m_stall_cnt, m_flush_cnt;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.pc = 0; b.rs1d = 0; b.rs2d = 0; b.imm = 0;
    b.rs1a = 0; b.rs2a = 0; b.rd = 0; b.aluop = 0;
    b.op1 = 0; b.op2 = 0; b.rw = 0; b.mr = 0; b.mw = 0;
    return b;
  endfunction

  function automatic instr_t from_id();
    instr_t n;
    n.valid = 1; n.pc = ID_PC; n.rs1d = ID_RS1_DATA; n.rs2d = ID_RS2_DATA; n.imm = ID_IMM;
    n.rs1a = ID_RS1_ADDR; n.rs2a = ID_RS2_ADDR; n.rd = ID_RD_ADDR; n.aluop = ID_ALUOP;
    n.op1 = ID_OP1_SEL; n.op2 = ID_OP2_SEL; n.rw = ID_REG_WRITE; n.mr = ID_MEM_READ;
    n.mw = ID_MEM_WRITE;
    return n;
  endfunction

  // Newest producer wins; x0 is hardwired zero so its reads are never bypassed.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (EXMEM_REG_WRITE && EXMEM_RD_ADDR == a) return EXMEM_RESULT;
    if (MEMWB_REG_WRITE && MEMWB_RD_ADDR == a) return MEMWB_RESULT;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    return ex_m.valid && ex_m.mr && ID_VALID && ex_m.rd != 0 &&
           (ex_m.rd == ID_RS1_ADDR || ex_m.rd == ID_RS2_ADDR);
  endfunction

  task automatic check_model(input int n);
    logic hz;
    hz = ref_hazard();
    chk("rnd_data1", DATA1, ex_m.op1 ? ex_m.pc : ref_operand(ex_m.rs1a, ex_m.rs1d));
    chk("rnd_data2", DATA2, ex_m.op2 ? ex_m.imm : ref_operand(ex_m.rs2a, ex_m.rs2d));
    chk("rnd_store", EX_STORE_DATA, ref_operand(ex_m.rs2a, ex_m.rs2d));
    chk("rnd_select", SELECT, ex_m.aluop);
    chk("rnd_valid", EX_VALID, ex_m.valid);
    chk("rnd_pc", EX_PC, ex_m.pc);
    chk("rnd_rd", EX_RD_ADDR, ex_m.rd);
    chk("rnd_ctrl", {EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE}, {ex_m.rw, ex_m.mr, ex_m.mw});
    chk("rnd_stall", STALL_ID, HOLD || (hz && !FLUSH));
    $display("rnd %0d: hold=%0b flush=%0b hz=%0b valid=%0b d1=%h d2=%h", n, HOLD, FLUSH, hz,
             EX_VALID, DATA1, DATA2);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [4:0]  rs1a, rs2a, rd, aluop;
    logic        op1, op2;
    logic [4:0]  ex_rd;  logic ex_wr;  logic [31:0] ex_res;
    logic [4:0]  wb_rd;  logic wb_wr;  logic [31:0] wb_res;
    logic [31:0] e_d1, e_d2, e_st;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd5, 32'd10, 32'd0, 32'h40, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 1'b0,
                5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 32'd10, 32'd10};
    vecs[1] = '{32'h11, 32'h22, 32'd0, 32'h44, 5'd4, 5'd2, 5'd3, ALU_SUB, 1'b0, 1'b0,
                5'd4, 1'b1, 32'h20, 5'd4, 1'b1, 32'h30, 32'h20, 32'h22, 32'h22};
    vecs[2] = '{32'h11, 32'h22, 32'd0, 32'h48, 5'd4, 5'd2, 5'd3, ALU_SUB, 1'b0, 1'b0,
                5'd4, 1'b0, 32'h20, 5'd4, 1'b1, 32'h30, 32'h30, 32'h22, 32'h22};
    vecs[3] = '{32'h55, 32'h66, 32'd0, 32'h4c, 5'd0, 5'd0, 5'd3, ALU_AND, 1'b0, 1'b0,
                5'd0, 1'b1, 32'h20, 5'd0, 1'b1, 32'h30, 32'h55, 32'h66, 32'h66};
    vecs[4] = '{32'h1, 32'h77, 32'hFFFFFFF0, 32'h1000, 5'd1, 5'd6, 5'd3, ALU_ADD, 1'b1, 1'b1,
                5'd0, 1'b0, 32'd0, 5'd6, 1'b1, 32'h99, 32'h1000, 32'hFFFFFFF0, 32'h99};
    vecs[5] = '{32'h1, 32'h2, 32'd0, 32'h50, 5'd9, 5'd9, 5'd3, ALU_XOR, 1'b0, 1'b0,
                5'd9, 1'b1, 32'hAA, 5'd9, 1'b1, 32'hBB, 32'hAA, 32'hAA, 32'hAA};

    idle();
    RESET = 1;
    repeat (2) tick();
    RESET = 0;
    #1;
    chk("reset_valid", EX_VALID, 0);
    chk("reset_select", SELECT, 0);
    chk("reset_data1", DATA1, 0);
    chk("reset_data2", DATA2, 0);
    chk("reset_stall", STALL_ID, 0);
    $display("reset: valid=%0b select=%h stall=%0b", EX_VALID, SELECT, STALL_ID);

    for (int i = 0; i < 6; i++) begin
      idle();
      ID_VALID = 1; ID_RS1_DATA = vecs[i].rs1d; ID_RS2_DATA = vecs[i].rs2d;
      ID_IMM = vecs[i].imm; ID_PC = vecs[i].pc; ID_RS1_ADDR = vecs[i].rs1a;
      ID_RS2_ADDR = vecs[i].rs2a; ID_RD_ADDR = vecs[i].rd; ID_ALUOP = vecs[i].aluop;
      ID_OP1_SEL = vecs[i].op1; ID_OP2_SEL = vecs[i].op2; ID_REG_WRITE = 1;
      tick();
      EXMEM_RD_ADDR = vecs[i].ex_rd; EXMEM_REG_WRITE = vecs[i].ex_wr; EXMEM_RESULT = vecs[i].ex_res;
      MEMWB_RD_ADDR = vecs[i].wb_rd; MEMWB_REG_WRITE = vecs[i].wb_wr; MEMWB_RESULT = vecs[i].wb_res;
      #1;
      chk($sformatf("vec%0d_data1", i), DATA1, vecs[i].e_d1);
      chk($sformatf("vec%0d_data2", i), DATA2, vecs[i].e_d2);
      chk($sformatf("vec%0d_store", i), EX_STORE_DATA, vecs[i].e_st);
      chk($sformatf("vec%0d_select", i), SELECT, vecs[i].aluop);
      chk($sformatf("vec%0d_valid", i), EX_VALID, 1);
      $display("vec %0d: d1=%h d2=%h st=%h sel=%h", i, DATA1, DATA2, EX_STORE_DATA, SELECT);
    end

    // Load-use: stall one cycle, bubble, then consumer enters with forwarded rs2.
    idle();
    ID_VALID = 1; ID_RD_ADDR = 7; ID_MEM_READ = 1; ID_REG_WRITE = 1; ID_RS1_ADDR = 1; ID_RS2_ADDR = 2;
    tick();
    ID_MEM_READ = 0; ID_RS2_ADDR = 7; ID_RD_ADDR = 8; ID_RS2_DATA = 32'h111; ID_ALUOP = ALU_OR;
    #1;
    chk("lu_stall", STALL_ID, 1);
    tick();
    chk("lu_bubble_valid", EX_VALID, 0);
    chk("lu_bubble_select", SELECT, 0);
    chk("lu_bubble_regwrite", EX_REG_WRITE, 0);
    chk("lu_stall_cleared", STALL_ID, 0);
    EXMEM_RD_ADDR = 7; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'hABC;
    tick();
    chk("lu_consumer_valid", EX_VALID, 1);
    chk("lu_consumer_rd", EX_RD_ADDR, 8);
    chk("lu_consumer_data2", DATA2, 32'hABC);
    $display("load-use: consumer rd=%0d d2=%h", EX_RD_ADDR, DATA2);

    // Flush coinciding with a load-use hazard.
    idle();
    ID_VALID = 1; ID_RD_ADDR = 7; ID_MEM_READ = 1; ID_REG_WRITE = 1;
    tick();
    ID_MEM_READ = 0; ID_RS1_ADDR = 7; ID_RD_ADDR = 9; FLUSH = 1;
    #1;
    chk("flush_lu_stall", STALL_ID, 0);
    tick();
    FLUSH = 0; ID_VALID = 0;
    #1;
    chk("flush_valid", EX_VALID, 0);
    $display("flush: valid=%0b stall=%0b", EX_VALID, STALL_ID);

    // Hold for three cycles with flush pulses and changing ID inputs.
    idle();
    ID_VALID = 1; ID_PC = 32'h100; ID_ALUOP = ALU_SUB; ID_RD_ADDR = 5; ID_RS1_ADDR = 3;
    ID_RS1_DATA = 32'h1234; ID_REG_WRITE = 1;
    tick();
    HOLD = 1;
    for (int i = 0; i < 3; i++) begin
      FLUSH = (i % 2) == 0; ID_PC = 32'h200 + i; ID_RD_ADDR = 9; ID_ALUOP = ALU_MUL;
      #1;
      chk($sformatf("hold%0d_stall", i), STALL_ID, 1);
      tick();
      chk($sformatf("hold%0d_valid", i), EX_VALID, 1);
      chk($sformatf("hold%0d_pc", i), EX_PC, 32'h100);
      chk($sformatf("hold%0d_select", i), SELECT, ALU_SUB);
      chk($sformatf("hold%0d_rd", i), EX_RD_ADDR, 5);
      chk($sformatf("hold%0d_data1", i), DATA1, 32'h1234);
      $display("hold %0d: pc=%h sel=%h", i, EX_PC, SELECT);
    end
    HOLD = 0; FLUSH = 0; ID_PC = 32'h300;
    tick();
    chk("after_hold_pc", EX_PC, 32'h300);
    chk("after_hold_rd", EX_RD_ADDR, 9);
    chk("after_hold_select", SELECT, ALU_MUL);

    // Randomized traffic against the reference model.
    idle();
    RESET = 1;
    tick();
    RESET = 0;
    ex_m = bubble();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      instr_t nxt;
      ID_VALID = ($urandom % 4) != 0;  ID_PC = $urandom;  ID_IMM = $urandom;
      ID_RS1_DATA = $urandom;  ID_RS2_DATA = $urandom;
      ID_RS1_ADDR = 5'($urandom % 4);  ID_RS2_ADDR = 5'($urandom % 4);
      ID_RD_ADDR = 5'($urandom % 4);   ID_ALUOP = 5'($urandom);
      ID_OP1_SEL = 1'($urandom);  ID_OP2_SEL = 1'($urandom);
      ID_REG_WRITE = 1'($urandom);  ID_MEM_READ = 1'($urandom);  ID_MEM_WRITE = 1'($urandom);
      EXMEM_RD_ADDR = 5'($urandom % 4);  EXMEM_REG_WRITE = 1'($urandom);  EXMEM_RESULT = $urandom;
      MEMWB_RD_ADDR = 5'($urandom % 4);  MEMWB_REG_WRITE = 1'($urandom);  MEMWB_RESULT = $urandom;
      FLUSH = ($urandom % 8) == 0;
      HOLD = ($urandom % 8) == 0;
      #1;
      check_model(n);
      nxt = ex_m;
      if (!HOLD) begin
        if (ref_hazard()) m_stall_cnt++;
        if (FLUSH) m_flush_cnt++;
        nxt = (FLUSH || ref_hazard() || !ID_VALID) ? bubble() : from_id();
      end
      tick();
      ex_m = nxt;
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_cnt", PERF_STALL_CNT, m_stall_cnt);
    chk("perf_flush_cnt", PERF_FLUSH_CNT, m_flush_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
